// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
//
// Command-buffering issue stage placed directly upstream of the combinational
// safealu. Commands (a, b, op) arrive over a valid/ready handshake and are
// queued in a DEPTH-entry circular FIFO. The head entry is driven to safealu.
// The returned result and flags are registered into a one-entry response slot
// that has its own valid/ready handshake. A sticky overflow flag records any
// captured overflow until software clears it.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_a, cmd_b, cmd_op        command operands and opcode (00 ADD, 01 SUB,
//                               10 AND, 11 OR)
//   alu_a, alu_b, alu_op        head command to safealu (0/0/00 when empty)
//   alu_result, alu_zero,
//   alu_carry, alu_overflow     safealu outputs
//   rsp_valid/rsp_ready         response handshake
//   rsp_result, rsp_zero,
//   rsp_carry, rsp_overflow     registered response
//   sticky_ovf, clr_sticky      sticky overflow flag and its clear
//   count                       FIFO occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module alu_issue_stage #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [W-1:0]               cmd_a,
    input  logic [W-1:0]               cmd_b,
    input  logic [1:0]                 cmd_op,

    output logic [W-1:0]               alu_a,
    output logic [W-1:0]               alu_b,
    output logic [1:0]                 alu_op,
    input  logic [W-1:0]               alu_result,
    input  logic                       alu_zero,
    input  logic                       alu_carry,
    input  logic                       alu_overflow,

    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [W-1:0]               rsp_result,
    output logic                       rsp_zero,
    output logic                       rsp_carry,
    output logic                       rsp_overflow,

    output logic                       sticky_ovf,
    input  logic                       clr_sticky,

    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [W-1:0]  entry_a_q  [DEPTH];
    logic [W-1:0]  entry_b_q  [DEPTH];
    logic [1:0]    entry_op_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    slot_state_t   state_q, state_d;

    logic [W-1:0]  rsp_result_q,   rsp_result_d;
    logic          rsp_zero_q,     rsp_zero_d;
    logic          rsp_carry_q,    rsp_carry_d;
    logic          rsp_overflow_q, rsp_overflow_d;
    logic          sticky_ovf_q,   sticky_ovf_d;

    logic          fifo_empty;
    logic          push;
    logic          capture;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    assign fifo_empty = (count_q == '0);

    // Ready depends only on registered occupancy: a full FIFO never accepts,
    // even if the head is being popped in the same cycle.
    assign cmd_ready  = !rst && (count_q < CW'(DEPTH));
    assign push       = cmd_valid && cmd_ready;

    // A command pushed into an empty FIFO is not visible here until the
    // next cycle, so there is no same-cycle bypass into the slot.
    assign capture    = !fifo_empty && ((state_q == SLOT_EMPTY) || rsp_ready);

    // ------------------------------------------------------------------
    // FIFO storage: one write-enabled register set per entry
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_q == PW'(gi))) begin
                    entry_a_q[gi]  <= cmd_a;
                    entry_b_q[gi]  <= cmd_b;
                    entry_op_q[gi] <= cmd_op;
                end
            end
        end
    endgenerate

    // Head of queue straight out of storage; forced to zero when empty so
    // safealu never sees stale operands.
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = 2'b00;
        if (!fifo_empty) begin
            alu_a  = entry_a_q[rd_ptr_q];
            alu_b  = entry_b_q[rd_ptr_q];
            alu_op = entry_op_q[rd_ptr_q];
        end
    end

    // ------------------------------------------------------------------
    // Pointer / occupancy next-state
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        // DEPTH is a power of two, so pointers wrap naturally.
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (capture) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        // Simultaneous push and pop leaves occupancy unchanged.
        if (push && !capture) begin
            count_d = count_q + CW'(1);
        end else if (!push && capture) begin
            count_d = count_q - CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Response slot FSM and data
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        rsp_result_d   = rsp_result_q;
        rsp_zero_d     = rsp_zero_q;
        rsp_carry_d    = rsp_carry_q;
        rsp_overflow_d = rsp_overflow_q;

        case (state_q)
            SLOT_EMPTY: begin
                if (capture) begin
                    state_d = SLOT_FULL;
                end
            end
            SLOT_FULL: begin
                // Consumer took the response and nothing replaces it.
                if (rsp_ready && !capture) begin
                    state_d = SLOT_EMPTY;
                end
            end
            default: begin
                state_d = SLOT_EMPTY;
            end
        endcase

        // Response data only ever changes on a capture edge; when the slot
        // drains the last values simply remain on the outputs.
        if (capture) begin
            rsp_result_d   = alu_result;
            rsp_zero_d     = alu_zero;
            rsp_carry_d    = alu_carry;
            rsp_overflow_d = alu_overflow;
        end
    end

    // ------------------------------------------------------------------
    // Sticky overflow: a captured overflow beats a simultaneous clear.
    // ------------------------------------------------------------------
    always_comb begin
        sticky_ovf_d = sticky_ovf_q;
        if (capture && alu_overflow) begin
            sticky_ovf_d = 1'b1;
        end else if (clr_sticky) begin
            sticky_ovf_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            state_q        <= SLOT_EMPTY;
            rsp_result_q   <= '0;
            rsp_zero_q     <= 1'b0;
            rsp_carry_q    <= 1'b0;
            rsp_overflow_q <= 1'b0;
            sticky_ovf_q   <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            state_q        <= state_d;
            rsp_result_q   <= rsp_result_d;
            rsp_zero_q     <= rsp_zero_d;
            rsp_carry_q    <= rsp_carry_d;
            rsp_overflow_q <= rsp_overflow_d;
            sticky_ovf_q   <= sticky_ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rsp_valid    = (state_q == SLOT_FULL);
    assign rsp_result   = rsp_result_q;
    assign rsp_zero     = rsp_zero_q;
    assign rsp_carry    = rsp_carry_q;
    assign rsp_overflow = rsp_overflow_q;
    assign sticky_ovf   = sticky_ovf_q;
    assign count        = count_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_stage
//
// Drives alu_issue_stage with directed sequences followed by randomized
// traffic. A behavioural safealu stand-in closes the alu_* loop. Expected
// behaviour comes from a queue-based transaction model of the stage plus an
// integer-arithmetic reference ALU. One line is printed per transaction.
// ---------------------------------------------------------------------------
module tb_alu_issue_stage;

    localparam int DEPTH = 4;
    localparam int W     = 8;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    logic           clk = 1'b0;
    logic           rst;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [W-1:0]   cmd_a, cmd_b;
    logic [1:0]     cmd_op;
    logic [W-1:0]   alu_a, alu_b;
    logic [1:0]     alu_op;
    logic [W-1:0]   alu_result;
    logic           alu_zero, alu_carry, alu_overflow;
    logic           rsp_valid, rsp_ready;
    logic [W-1:0]   rsp_result;
    logic           rsp_zero, rsp_carry, rsp_overflow;
    logic           sticky_ovf, clr_sticky;
    logic [$clog2(DEPTH):0] count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(.DEPTH(DEPTH), .W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_op       (cmd_op),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .alu_carry    (alu_carry),
        .alu_overflow (alu_overflow),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_zero     (rsp_zero),
        .rsp_carry    (rsp_carry),
        .rsp_overflow (rsp_overflow),
        .sticky_ovf   (sticky_ovf),
        .clr_sticky   (clr_sticky),
        .count        (count)
    );

    // Stand-in for the combinational safealu, bit-level form.
    always_comb begin
        logic [W:0] ext;
        ext          = '0;
        alu_result   = '0;
        alu_carry    = 1'b0;
        alu_overflow = 1'b0;
        case (alu_op)
            OP_ADD: begin
                ext          = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result   = ext[W-1:0];
                alu_carry    = ext[W];
                alu_overflow = (alu_a[W-1] == alu_b[W-1]) && (alu_result[W-1] != alu_a[W-1]);
            end
            OP_SUB: begin
                ext          = {1'b0, alu_a} - {1'b0, alu_b};
                alu_result   = ext[W-1:0];
                alu_carry    = ext[W];
                alu_overflow = (alu_a[W-1] != alu_b[W-1]) && (alu_result[W-1] != alu_a[W-1]);
            end
            OP_AND: alu_result = alu_a & alu_b;
            default: alu_result = alu_a | alu_b;
        endcase
        alu_zero = (alu_result == '0);
    end

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   op;
    } cmd_t;

    typedef struct packed {
        logic [W-1:0] res;
        logic         zero;
        logic         carry;
        logic         ovf;
    } rsp_t;

    cmd_t m_fifo[$];
    logic m_slot_valid = 1'b0;
    rsp_t m_slot       = '0;
    logic m_sticky     = 1'b0;

    // Integer-arithmetic reference: signed overflow checked by range.
    function automatic rsp_t ref_alu(input cmd_t c);
        rsp_t r;
        int ua, ub, sa, sb, u, s;
        ua = int'(c.a);
        ub = int'(c.b);
        sa = (ua >= 128) ? ua - 256 : ua;
        sb = (ub >= 128) ? ub - 256 : ub;
        r  = '0;
        case (c.op)
            OP_ADD: begin
                u = ua + ub;
                s = sa + sb;
                r.res   = u[W-1:0];
                r.carry = (u > 255);
                r.ovf   = (s > 127) || (s < -128);
            end
            OP_SUB: begin
                u = ua - ub;
                s = sa - sb;
                r.res   = u[W-1:0];
                r.carry = (ua < ub);
                r.ovf   = (s > 127) || (s < -128);
            end
            OP_AND: r.res = c.a & c.b;
            default: r.res = c.a | c.b;
        endcase
        r.zero = (r.res == '0);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check combinational outputs and step the
    // model before the edge, then check registered outputs after it.
    task automatic cyc(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] op, input logic rr, input logic clr, input logic r);
        cmd_t c;
        cmd_t head;
        rsp_t rr_ref;
        logic cap, psh;
        c = '{a: a, b: b, op: op};
        rst        = r;
        cmd_valid  = v;
        cmd_a      = a;
        cmd_b      = b;
        cmd_op     = op;
        rsp_ready  = rr;
        clr_sticky = clr;

        @(negedge clk);
        head = (m_fifo.size() > 0) ? m_fifo[0] : cmd_t'('0);
        check("cmd_ready", 32'(cmd_ready), 32'(!r && (m_fifo.size() < DEPTH)));
        check("alu_drive", 32'({alu_a, alu_b, alu_op}), 32'({head.a, head.b, head.op}));

        psh = 1'b0;
        cap = 1'b0;
        if (r) begin
            m_fifo.delete();
            m_slot_valid = 1'b0;
            m_slot       = '0;
            m_sticky     = 1'b0;
        end else begin
            psh = v && (m_fifo.size() < DEPTH);
            cap = (m_fifo.size() > 0) && (!m_slot_valid || rr);
            if (cap) begin
                rr_ref = ref_alu(m_fifo.pop_front());
                m_slot       = rr_ref;
                m_slot_valid = 1'b1;
                if (rr_ref.ovf) m_sticky = 1'b1;
                else if (clr)   m_sticky = 1'b0;
            end else begin
                if (m_slot_valid && rr) m_slot_valid = 1'b0;
                if (clr) m_sticky = 1'b0;
            end
            if (psh) m_fifo.push_back(c);
        end

        @(posedge clk);
        #1;
        check("rsp_valid", 32'(rsp_valid), 32'(m_slot_valid));
        check("rsp_data", 32'({rsp_result, rsp_zero, rsp_carry, rsp_overflow}),
              32'({m_slot.res, m_slot.zero, m_slot.carry, m_slot.ovf}));
        check("sticky", 32'(sticky_ovf), 32'(m_sticky));
        check("count", 32'(count), 32'(m_fifo.size()));
        $display("cyc rst=%0b push=%0b a=%02h b=%02h op=%0d cap=%0b rv=%0b res=%02h zcv=%0b%0b%0b sticky=%0b cnt=%0d",
                 r, psh, a, b, op, cap, rsp_valid, rsp_result, rsp_zero, rsp_carry,
                 rsp_overflow, sticky_ovf, count);
    endtask

    task automatic idle(input logic rr);
        cyc(1'b0, '0, '0, OP_ADD, rr, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0;
        rsp_ready = 1'b0; clr_sticky = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        cyc(1'b0, '0, '0, OP_ADD, 1'b0, 1'b0, 1'b1);
        check("reset_outputs", 32'({rsp_valid, rsp_result, rsp_zero, rsp_carry, rsp_overflow, sticky_ovf, count}), 32'(0));

        // Single ADD, one cycle latency
        cyc(1'b1, 8'd10, 8'd20, OP_ADD, 1'b1, 1'b0, 1'b0);
        check("add_lat_not_yet", 32'(rsp_valid), 32'(0));
        idle(1'b0);
        check("add_10_20", 32'({rsp_valid, rsp_result, rsp_zero, rsp_carry, rsp_overflow}), 32'({1'b1, 8'h1E, 3'b000}));
        check("add_count0", 32'(count), 32'(0));
        idle(1'b1);

        // Back-to-back stream
        cyc(1'b1, 8'd200, 8'd100, OP_ADD, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 8'd127, 8'd1,   OP_ADD, 1'b1, 1'b0, 1'b0);
        check("stream_r1", 32'({rsp_result, rsp_carry, rsp_overflow}), 32'({8'h2C, 2'b10}));
        cyc(1'b1, 8'd20,  8'd50,  OP_SUB, 1'b1, 1'b0, 1'b0);
        check("stream_r2", 32'({rsp_result, rsp_overflow, sticky_ovf}), 32'({8'h80, 2'b11}));
        cyc(1'b1, 8'hAA,  8'hCC,  OP_AND, 1'b1, 1'b0, 1'b0);
        check("stream_r3", 32'({rsp_result, rsp_carry}), 32'({8'hE2, 1'b1}));
        cyc(1'b1, 8'hAA,  8'h55,  OP_OR,  1'b1, 1'b0, 1'b0);
        check("stream_r4", 32'(rsp_result), 32'(8'h88));
        cyc(1'b1, 8'd0,   8'd0,   OP_SUB, 1'b1, 1'b0, 1'b0);
        check("stream_r5", 32'(rsp_result), 32'(8'hFF));
        idle(1'b1);
        check("stream_r6", 32'({rsp_valid, rsp_result, rsp_zero, sticky_ovf}), 32'({1'b1, 8'h00, 1'b1, 1'b1}));
        idle(1'b1);

        // Backpressure: five commands fill FIFO plus slot
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(i + 1), 8'(3), OP_ADD, 1'b0, 1'b0, 1'b0);
        check("bp_ready_low", 32'(cmd_ready), 32'(0));
        check("bp_count", 32'(count), 32'(DEPTH));
        check("bp_hold_first", 32'(rsp_result), 32'(8'd4));
        cyc(1'b1, 8'h77, 8'h77, OP_OR, 1'b0, 1'b0, 1'b0); // refused while full
        for (int i = 0; i < 6; i++) idle(1'b1);
        check("bp_ready_back", 32'(cmd_ready), 32'(1));

        // Sticky: set beats clear, then clear alone
        cyc(1'b1, 8'd127, 8'd1, OP_ADD, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        cyc(1'b1, 8'd127, 8'd1, OP_ADD, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, '0, '0, OP_ADD, 1'b1, 1'b1, 1'b0);
        check("sticky_set_wins", 32'(sticky_ovf), 32'(1));
        cyc(1'b0, '0, '0, OP_ADD, 1'b1, 1'b1, 1'b0);
        check("sticky_cleared", 32'(sticky_ovf), 32'(0));

        // Reset mid-operation: slot full, three entries queued
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'(16 * i), 8'd5, OP_SUB, 1'b0, 1'b0, 1'b0);
        check("pre_rst_count", 32'(count), 32'(3));
        cyc(1'b1, 8'd1, 8'd1, OP_ADD, 1'b1, 1'b0, 1'b1);
        check("mid_rst", 32'({rsp_valid, rsp_result, rsp_zero, rsp_carry, rsp_overflow, sticky_ovf, count}), 32'(0));
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            check("no_stale_rsp", 32'(rsp_valid), 32'(0));
        end

        // Randomized traffic with random backpressure
        for (int i = 0; i < 12 * DEPTH; i++) begin
            cyc(($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 2'($urandom),
                1'($urandom), ($urandom_range(0, 9) == 0), 1'b0);
        end
        for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);
        check("final_drain", 32'({rsp_valid, count}), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
